rts_cts_flow_ctrl: RTL
======================

# rts_cts_flow_ctrl

Hardware flow-control controller for the UART RTS/CTS pin pair. Synchronises and glitch-filters the asynchronous `rts` pin into a transmit-permit, and drives a registered `cts` pin from the receive-buffer fill level with hysteresis and minimum hold-off. Sits between the IOB pads and the UART TX/RX cores, replacing the direct rts→cts pad path with a clocked, loop-free controller.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `rts` (≥2).
- `FILT_CYC`, 4: cycles `rts` must be stable after sync before a change is accepted (≥1).
- `LEVEL_W`, 5: width of `rx_level`.
- `HI_WATER`, 24: level at or above which CTS is dropped.
- `LO_WATER`, 8: level at or below which CTS may reassert (LO_WATER < HI_WATER).
- `HOLD_CYC`, 16: minimum cycles CTS stays low once dropped (≥1).
- `TIMEOUT_CYC`, 1024: TX stall watchdog limit (used only with the timeout macro).

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rts` in 1: asynchronous pin from peer; high = peer accepts data.
- `rx_level` in LEVEL_W: current RX buffer occupancy, synchronous to `clk`.
- `tx_valid` in 1: TX core has a frame pending.
- `tx_ready` out 1: TX core may start a new frame.
- `cts` out 1: registered pin to peer; high = we accept data.
- `rts_sync` out 1: filtered rts level.
- `timeout` out 1: TX stall flag.

## Operation
- Reset values: `cts`=0, `tx_ready`=0, `rts_sync`=0, `timeout`=0; sync chain and filter counter cleared; FSM in OFF.
- RTS path: SYNC_STAGES flops, then a filter. Filter counter resets whenever the synced value equals `rts_sync`; otherwise it increments. `rts_sync` toggles when the count reaches FILT_CYC. A glitch shorter than FILT_CYC cycles never changes `rts_sync`.
- `tx_ready` = `rts_sync`, registered. The TX core only samples it at frame start, so a frame in flight always completes.
- CTS FSM (package enum):
  - OFF: `cts`=0. First cycle after reset → OPEN if `rx_level` < HI_WATER, else HOLD.
  - OPEN: `cts`=1. `rx_level` ≥ HI_WATER → HOLD, clearing the hold counter.
  - HOLD: `cts`=0. Hold counter increments. At HOLD_CYC−1 → THROTTLED.
  - THROTTLED: `cts`=0. `rx_level` ≤ LO_WATER → OPEN.
- Levels between the two water marks never change state (hysteresis).
- Comparisons are unsigned at LEVEL_W bits. HI_WATER and LO_WATER must fit in LEVEL_W bits; this is checked with an elaboration assertion.
- `rst` mid-operation returns everything to the reset values on the next edge, regardless of FSM state or counters.

## Timing
- `rts` pin edge → `rts_sync` change: SYNC_STAGES+FILT_CYC cycles. `tx_ready` follows one cycle later.
- `rx_level` crossing HI_WATER sampled at edge N → `cts` low after edge N+1.
- `cts` low time ≥ HOLD_CYC cycles even if `rx_level` is already ≤ LO_WATER during HOLD.
- `cts` rises one cycle after the THROTTLED condition is sampled.
- Simultaneous events: when `rx_level` ≥ HI_WATER and the hold count expires in the same cycle, the FSM goes to THROTTLED (no re-entry into HOLD).

## Configuration
- `RTS_CTS_TIMEOUT_EN` defined:
  - Stall counter increments while `tx_valid`=1 and `rts_sync`=0, saturating at TIMEOUT_CYC.
  - `timeout` sets when the count reaches TIMEOUT_CYC and is sticky.
  - Counter and flag clear when `rts_sync`=1 or `tx_valid`=0.
- `RTS_CTS_TIMEOUT_EN` undefined: counter is not built and `timeout` is tied to 0.

## Structure
- Package `rts_cts_pkg`: the FSM state enum (OFF, OPEN, HOLD, THROTTLED) and the default parameter constants.
- Sub-module `rts_filter`: synchroniser chain plus stability filter, with parameters SYNC_STAGES and FILT_CYC. Output is `rts_sync`.
- The top level holds the CTS FSM, hold counter, `tx_ready` register and the optional watchdog.

## Test plan
- Reset, then `rx_level`=0 → `cts`=0 for the reset cycles plus one, then `cts`=1; `tx_ready`=0 while `rts`=0.
- `rts` 0→1 held → `rts_sync`=1 after exactly 6 cycles and `tx_ready`=1 after 7; a 3-cycle `rts` pulse → `rts_sync` stays 0.
- `rx_level` ramps 0→24 → `cts` falls one cycle after 24 is sampled; `rx_level`=5 immediately → `cts` held low 16 cycles, then rises one cycle later.
- `rx_level` oscillates between 10 and 20 while OPEN → `cts` stays 1; the same oscillation while THROTTLED → `cts` stays 0.
- `rst` asserted during HOLD with count 7 → next cycle `cts`=0 and FSM in OFF; after release with `rx_level`=30 → FSM goes to HOLD and `cts` stays 0.
- With `RTS_CTS_TIMEOUT_EN`: `tx_valid`=1 and `rts`=0 for 1024 cycles → `timeout`=1; `rts`→1 → `timeout` clears once `rts_sync` rises. Without the macro → `timeout` stays 0 throughout.

Source files
------------

// File: rtl/rts_cts_pkg.sv
// Shared types and default constants for the RTS/CTS flow-control controller.
// Optional TX stall watchdog is enabled by defining RTS_CTS_TIMEOUT_EN.
package rts_cts_pkg;

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      OPEN      = 2'd1,
      HOLD      = 2'd2,
      THROTTLED = 2'd3
   } cts_state_t;

   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_FILT_CYC    = 4;
   localparam int unsigned DEF_LEVEL_W     = 5;
   localparam int unsigned DEF_HI_WATER    = 24;
   localparam int unsigned DEF_LO_WATER    = 8;
   localparam int unsigned DEF_HOLD_CYC    = 16;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/rts_filter.sv
// Synchroniser chain plus stability filter for the asynchronous rts pin.
// A new level is only accepted once it has been stable for FILT_CYC cycles.
module rts_filter
   import rts_cts_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned FILT_CYC    = DEF_FILT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic rts,
   output logic rts_sync
);

   localparam int unsigned CNT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

   logic [SYNC_STAGES-1:0] chain;
   logic [CNT_W-1:0]       filt_cnt;
   logic                   synced;

   assign synced = chain[SYNC_STAGES-1];

   // Counter only runs while the synced pin disagrees with the accepted level
   always_ff @(posedge clk) begin
      if (rst) begin
         chain    <= '0;
         filt_cnt <= '0;
         rts_sync <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], rts};
         if (synced == rts_sync) begin
            filt_cnt <= '0;
         end else if (filt_cnt == CNT_LAST) begin
            rts_sync <= ~rts_sync;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rts_cts_flow_ctrl.sv
// RTS/CTS flow-control controller: filtered TX permit and hysteretic CTS FSM.
// Define RTS_CTS_TIMEOUT_EN to build the TX stall watchdog driving `timeout`.
module rts_cts_flow_ctrl
   import rts_cts_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned FILT_CYC    = DEF_FILT_CYC,
   parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
   parameter int unsigned HI_WATER    = DEF_HI_WATER,
   parameter int unsigned LO_WATER    = DEF_LO_WATER,
   parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rts,
   input  logic [LEVEL_W-1:0] rx_level,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               cts,
   output logic               rts_sync,
   output logic               timeout
);

   if (HI_WATER >= (1 << LEVEL_W)) begin : g_bad_hi
      $fatal(1, "HI_WATER does not fit in LEVEL_W bits");
   end
   if (LO_WATER >= HI_WATER) begin : g_bad_lo
      $fatal(1, "LO_WATER must be below HI_WATER");
   end
   if (SYNC_STAGES < 2 || FILT_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cfg
      $fatal(1, "SYNC_STAGES >= 2, FILT_CYC >= 1 and HOLD_CYC >= 1 required");
   end

   localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [LEVEL_W-1:0] HI_LV     = LEVEL_W'(HI_WATER);
   localparam logic [LEVEL_W-1:0] LO_LV     = LEVEL_W'(LO_WATER);

   cts_state_t        state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

   rts_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC)
   ) u_rts_filter (
      .clk      (clk),
      .rst      (rst),
      .rts      (rts),
      .rts_sync (rts_sync)
   );

   // cts is registered from the state, so it lags a state change by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= OFF;
         hold_cnt <= '0;
         cts      <= 1'b0;
         tx_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         cts      <= (state == OPEN);
         tx_ready <= rts_sync;
      end
   end

   // HOLD ignores rx_level entirely, which guarantees the minimum hold-off
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         OFF: begin
            hold_cnt_nxt = '0;
            state_nxt    = (rx_level >= HI_LV) ? HOLD : OPEN;
         end
         OPEN: begin
            if (rx_level >= HI_LV) begin
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nxt    = THROTTLED;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         THROTTLED: begin
            if (rx_level <= LO_LV) begin
               state_nxt = OPEN;
            end
         end
         default: begin
            state_nxt    = OFF;
            hold_cnt_nxt = '0;
         end
      endcase
   end

`ifdef RTS_CTS_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

   logic [TO_W-1:0] stall_cnt;

   // Saturating stall counter; the flag stays set until the stall is resolved
   always_ff @(posedge clk) begin
      if (rst || rts_sync || !tx_valid) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else if (stall_cnt != TO_MAX) begin
         stall_cnt <= stall_cnt + TO_W'(1);
         if (stall_cnt == TO_MAX - TO_W'(1)) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = tx_valid ^ TIMEOUT_CYC[0];
   assign timeout    = 1'b0;
`endif

endmodule
